// File: rtl/pit_bus_sequencer.sv
// pit_bus_sequencer: turns one program or latch-read request into
// timed 8253 bus cycles (ctrl word, then count bytes).
module pit_bus_sequencer #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1,
  parameter int RECOV_CYC  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [1:0]  req_chan,
  input  logic [1:0]  req_rw,
  input  logic [2:0]  req_mode,
  input  logic [15:0] req_count,
  output logic        done,
  output logic        err,
  output logic [15:0] rd_count,
  output logic        cs_n,
  output logic        a1,
  output logic        a0,
  output logic        wr_n,
  output logic        rd_n,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  d_in
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, RECOV, DONE, ERR
  } state_t;

  localparam logic [3:0] S_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] T_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] H_LD = 4'(HOLD_CYC - 1);
  localparam logic [3:0] R_LD = 4'(RECOV_CYC - 1);

  state_t      state, nxt;
  logic [3:0]  cnt, nxt_cnt;
  logic [1:0]  idx, nxt_idx;
  logic        op_q;
  logic [1:0]  chan_q, rw_q;
  logic [2:0]  mode_q;
  logic [15:0] count_q;
  logic [7:0]  lsb_q, msb_q;

  logic        accept, bad, last, cap, cap_hi;
  logic [1:0]  last_idx;
  logic        e_op;
  logic [1:0]  e_chan, e_rw;
  logic [2:0]  e_mode;
  logic [15:0] e_count;
  logic        bus_d, strb_d, wcyc, byte_hi;
  logic [1:0]  addr_d;
  logic [7:0]  ctrl_d, dout_d;

  assign accept = (state == IDLE) && req_valid;
  assign bad = (req_chan == 2'd3)
             || (!req_op && (req_mode > 3'd5))
             || (req_op && (req_rw == 2'b00));
  assign last = (cnt == 4'd0);
  assign last_idx = (rw_q == 2'b11) ? 2'd2 :
                    (rw_q == 2'b00) ? 2'd0 : 2'd1;
  assign cap = (state == STROBE) && last && (idx != 2'd0) && op_q;
  assign cap_hi = (rw_q == 2'b10) || (idx == 2'd2);

  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    nxt_idx = idx;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          nxt_idx = 2'd0;
          if (bad) begin
            nxt = ERR;
          end else begin
            nxt     = SETUP;
            nxt_cnt = S_LD;
          end
        end
      end
      SETUP: begin
        if (last) begin
          nxt     = STROBE;
          nxt_cnt = T_LD;
        end else begin
          nxt_cnt = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (last) begin
          nxt     = HOLD;
          nxt_cnt = H_LD;
        end else begin
          nxt_cnt = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (!last) begin
          nxt_cnt = cnt - 4'd1;
        end else if (idx == last_idx) begin
          nxt = DONE;
        end else begin
          nxt     = RECOV;
          nxt_cnt = R_LD;
        end
      end
      RECOV: begin
        if (last) begin
          nxt     = SETUP;
          nxt_cnt = S_LD;
          nxt_idx = idx + 2'd1;
        end else begin
          nxt_cnt = cnt - 4'd1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Pins are registered from the next state so they change
  // on the same edge the FSM enters each phase.
  always_comb begin
    e_op    = (state == IDLE) ? req_op    : op_q;
    e_chan  = (state == IDLE) ? req_chan  : chan_q;
    e_rw    = (state == IDLE) ? req_rw    : rw_q;
    e_mode  = (state == IDLE) ? req_mode  : mode_q;
    e_count = (state == IDLE) ? req_count : count_q;
    bus_d   = (nxt == SETUP) || (nxt == STROBE) || (nxt == HOLD);
    strb_d  = (nxt == STROBE);
    wcyc    = (nxt_idx == 2'd0) || !e_op;
    byte_hi = (e_rw == 2'b10) || (nxt_idx == 2'd2);
    ctrl_d  = e_op ? {e_chan, 6'b0} : {e_chan, e_rw, e_mode, 1'b0};
    addr_d  = 2'b00;
    dout_d  = 8'h00;
    if (bus_d) begin
      addr_d = (nxt_idx == 2'd0) ? 2'b11 : e_chan;
    end
    if (bus_d && wcyc) begin
      if (nxt_idx == 2'd0) dout_d = ctrl_d;
      else if (byte_hi)    dout_d = e_count[15:8];
      else                 dout_d = e_count[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      idx       <= 2'd0;
      op_q      <= 1'b0;
      chan_q    <= 2'd0;
      rw_q      <= 2'd0;
      mode_q    <= 3'd0;
      count_q   <= 16'd0;
      lsb_q     <= 8'd0;
      msb_q     <= 8'd0;
      rd_count  <= 16'd0;
      req_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      cs_n      <= 1'b1;
      a1        <= 1'b0;
      a0        <= 1'b0;
      wr_n      <= 1'b1;
      rd_n      <= 1'b1;
      d_out     <= 8'd0;
      d_oe      <= 1'b0;
    end else begin
      state <= nxt;
      cnt   <= nxt_cnt;
      idx   <= nxt_idx;
      if (accept) begin
        op_q    <= req_op;
        chan_q  <= req_chan;
        rw_q    <= req_rw;
        mode_q  <= req_mode;
        count_q <= req_count;
        lsb_q   <= 8'd0;
        msb_q   <= 8'd0;
      end
      if (cap) begin
        if (cap_hi) msb_q <= d_in;
        else        lsb_q <= d_in;
      end
      if ((nxt == DONE) && op_q) rd_count <= {msb_q, lsb_q};
      req_ready  <= (nxt == IDLE);
      done       <= (nxt == DONE);
      err        <= (nxt == ERR);
      cs_n       <= !bus_d;
      {a1, a0}   <= addr_d;
      wr_n       <= !(strb_d && wcyc);
      rd_n       <= !(strb_d && !wcyc);
      d_out      <= dout_d;
      d_oe       <= bus_d && wcyc;
    end
  end

endmodule

// File: tb/tb_pit_bus_sequencer.sv
// tb_pit_bus_sequencer: random requests against a bus-level model
// on a default-timed and a slow-timed instance.
`timescale 1ns/1ps
module tb_pit_bus_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        rv = 1'b0;
  logic        req_op = 1'b0;
  logic [1:0]  req_chan = 2'd0;
  logic [1:0]  req_rw = 2'd0;
  logic [2:0]  req_mode = 3'd0;
  logic [15:0] req_count = 16'd0;
  logic [7:0]  d_in = 8'd0;
  logic        v0, v1;

  logic rdy0, dn0, er0, cs0, a10, a00, wr0, rd0, oe0;
  logic rdy1, dn1, er1, cs1, a11, a01, wr1, rd1, oe1;
  logic [15:0] rc0, rc1;
  logic [7:0]  do0, do1;

  assign v0 = rv && !sel;
  assign v1 = rv && sel;

  pit_bus_sequencer dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0),
    .req_op(req_op), .req_chan(req_chan), .req_rw(req_rw),
    .req_mode(req_mode), .req_count(req_count),
    .done(dn0), .err(er0), .rd_count(rc0), .cs_n(cs0),
    .a1(a10), .a0(a00), .wr_n(wr0), .rd_n(rd0),
    .d_out(do0), .d_oe(oe0), .d_in(d_in)
  );

  pit_bus_sequencer #(
    .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2), .RECOV_CYC(2)
  ) dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_ready(rdy1),
    .req_op(req_op), .req_chan(req_chan), .req_rw(req_rw),
    .req_mode(req_mode), .req_count(req_count),
    .done(dn1), .err(er1), .rd_count(rc1), .cs_n(cs1),
    .a1(a11), .a0(a01), .wr_n(wr1), .rd_n(rd1),
    .d_out(do1), .d_oe(oe1), .d_in(d_in)
  );

  logic m_rdy, m_dn, m_er, m_cs, m_a1, m_a0, m_wr, m_rd, m_oe;
  logic [15:0] m_rc;
  logic [7:0]  m_do;
  assign m_rdy = sel ? rdy1 : rdy0;
  assign m_dn  = sel ? dn1 : dn0;
  assign m_er  = sel ? er1 : er0;
  assign m_cs  = sel ? cs1 : cs0;
  assign m_a1  = sel ? a11 : a10;
  assign m_a0  = sel ? a01 : a00;
  assign m_wr  = sel ? wr1 : wr0;
  assign m_rd  = sel ? rd1 : rd0;
  assign m_oe  = sel ? oe1 : oe0;
  assign m_rc  = sel ? rc1 : rc0;
  assign m_do  = sel ? do1 : do0;

  int tests = 0;
  int fails = 0;

  // Bus transcript: {count[1:0], 3 x {rd, a1, a0, data}}
  logic [34:0] obs_sig, exp_sig;
  // Phase lengths in nibbles: S,T,H per bus cycle, R between
  logic [43:0] obs_tim, exp_tim;
  int obs_done, obs_done_n, obs_err, obs_err_n, obs_ready, obs_viol;
  int exp_done, exp_ready, exp_err;
  logic [15:0] obs_rd, exp_rd;
  logic [7:0]  rq_b [2];
  logic [15:0] last_rd [2];

  task automatic model(input logic s, input logic op,
                       input logic [1:0] ch, input logic [1:0] rw,
                       input logic [2:0] md, input logic [15:0] cnt);
    int S, T, H, R, n;
    logic [7:0] b [2];
    S = s ? 2 : 1;
    T = s ? 3 : 2;
    H = s ? 2 : 1;
    R = s ? 2 : 1;
    exp_sig = '0;
    exp_tim = '0;
    exp_err = 0;
    exp_done = 0;
    exp_rd = last_rd[s];
    if (ch == 2'd3 || (!op && md > 3'd5) || (op && rw == 2'd0)) begin
      exp_err = 1;
      exp_ready = 2;
    end else begin
      n = (rw == 2'd3) ? 3 : (rw == 2'd0) ? 1 : 2;
      exp_sig[34:33] = 2'(n);
      exp_sig[32:22] = {1'b0, 2'b11,
        op ? {ch, 6'b0} : {ch, rw, md, 1'b0}};
      if (op) begin
        b[0] = rq_b[0];
        b[1] = rq_b[1];
        if (rw == 2'd1) exp_rd = {8'h00, rq_b[0]};
        else if (rw == 2'd2) exp_rd = {rq_b[0], 8'h00};
        else exp_rd = {rq_b[1], rq_b[0]};
        last_rd[s] = exp_rd;
      end else begin
        b[0] = (rw == 2'd2) ? cnt[15:8] : cnt[7:0];
        b[1] = cnt[15:8];
      end
      for (int k = 1; k < n; k++)
        exp_sig[32-11*k -: 11] = {op, ch, b[k-1]};
      for (int k = 0; k < n; k++) begin
        if (k > 0) exp_tim = {exp_tim[39:0], 4'(R)};
        exp_tim = {exp_tim[31:0], 4'(S), 4'(T), 4'(H)};
      end
      exp_done = n * (S + T + H) + (n - 1) * R + 1;
      exp_ready = exp_done + 1;
    end
  endtask

  task automatic run_req(input logic s, input logic op,
                         input logic [1:0] ch, input logic [1:0] rw,
                         input logic [2:0] md, input logic [15:0] cnt,
                         input logic hv);
    int T, ph, sl, tl, hl, gl, ri, nev;
    bit in_bus, gap_open;
    logic [1:0] a_s;
    logic [7:0] d_s, rbyte;
    logic o_s, rdev;
    T = s ? 3 : 2;
    sel = s;
    obs_sig = '0; obs_tim = '0; obs_viol = 0;
    obs_done = 0; obs_done_n = 0; obs_err = 0; obs_err_n = 0;
    obs_ready = 0;
    nev = 0; ri = 0; ph = 0; sl = 0; tl = 0; hl = 0; gl = 0;
    in_bus = 0; gap_open = 0; rbyte = 8'h00;
    a_s = 2'b00; d_s = 8'h00; o_s = 1'b0;
    for (int w = 0; w < 60 && m_rdy !== 1'b1; w++) begin
      @(posedge clk); #1;
    end
    req_op = op; req_chan = ch; req_rw = rw;
    req_mode = md; req_count = cnt;
    rv = 1'b1;
    @(posedge clk); #1;
    rv = hv;
    req_op = 1'($urandom); req_chan = 2'($urandom);
    req_rw = 2'($urandom); req_mode = 3'($urandom);
    req_count = 16'($urandom);
    for (int c = 1; c <= 90; c++) begin
      if (m_dn) begin obs_done_n++; if (obs_done == 0) obs_done = c; end
      if (m_er) begin obs_err_n++; if (obs_err == 0) obs_err = c; end
      if (!m_wr && !m_rd) obs_viol++;
      if (!m_rd && m_oe) obs_viol++;
      if (!m_cs) begin
        if (!in_bus) begin
          if (gap_open) obs_tim = {obs_tim[39:0], 4'(gl)};
          in_bus = 1; ph = 0; sl = 0; tl = 0; hl = 0;
          a_s = {m_a1, m_a0}; d_s = m_do; o_s = m_oe;
        end else if ({m_a1, m_a0} !== a_s || m_do !== d_s
                     || m_oe !== o_s) begin
          obs_viol++;
        end
        if (!m_wr || !m_rd) begin
          if (ph == 2) obs_viol++;
          if (ph == 0) begin
            ph = 1;
            rdev = !m_rd;
            if (rdev && ri < 2) begin rbyte = rq_b[ri]; ri++; end
            if (nev < 3)
              obs_sig[32-11*nev -: 11] =
                {rdev, m_a1, m_a0, rdev ? rbyte : m_do};
            nev++;
            if (!m_wr && !m_oe) obs_viol++;
          end
          tl++;
        end else if (ph == 0) begin
          sl++;
        end else begin
          ph = 2; hl++;
        end
      end else begin
        if (in_bus) begin
          obs_tim = {obs_tim[31:0], 4'(sl), 4'(tl), 4'(hl)};
          in_bus = 0; gap_open = 1; gl = 0;
        end
        if (gap_open) gl++;
        if (!m_wr || !m_rd || m_oe) obs_viol++;
      end
      if (!m_rd) d_in = (tl == T) ? rbyte : ~rbyte;
      else d_in = 8'($urandom);
      if (m_rdy === 1'b1) begin obs_ready = c; break; end
      @(posedge clk); #1;
    end
    rv = 1'b0;
    obs_sig[34:33] = 2'((nev > 3) ? 3 : nev);
    obs_rd = m_rc;
  endtask

  task automatic test_reset();
    rst = 1'b1; rv = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({cs0, wr0, rd0, a10, a00, oe0, do0} !== 14'b111000_00000000) begin
      fails++;
      $display("FAIL reset_pins0 got=%b want=11100000000000",
               {cs0, wr0, rd0, a10, a00, oe0, do0});
    end
    tests++;
    if ({cs1, wr1, rd1, a11, a01, oe1, do1} !== 14'b111000_00000000) begin
      fails++;
      $display("FAIL reset_pins1 got=%b want=11100000000000",
               {cs1, wr1, rd1, a11, a01, oe1, do1});
    end
    tests++;
    if ({rc0, dn0, er0, rc1, dn1, er1} !== 36'h0) begin
      fails++;
      $display("FAIL reset_status got=%h want=0",
               {rc0, dn0, er0, rc1, dn1, er1});
    end
    rst = 1'b0;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    @(posedge clk); #1;
    tests++;
    if ({rdy0, rdy1} !== 2'b11) begin
      fails++;
      $display("FAIL reset_ready got=%b want=11", {rdy0, rdy1});
    end
  endtask

  task automatic test_program();
    logic [1:0] ch, rw;
    logic [2:0] md;
    logic [15:0] cnt;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin ch = 0; rw = 3; md = 3; cnt = 16'h1234; end
      else if (i == 1) begin ch = 2; rw = 1; md = 2; cnt = 16'h0040; end
      else begin
        ch = 2'($urandom_range(0, 2)); rw = 2'($urandom);
        md = 3'($urandom_range(0, 5)); cnt = 16'($urandom);
      end
      model(1'b0, 1'b0, ch, rw, md, cnt);
      run_req(1'b0, 1'b0, ch, rw, md, cnt, 1'b0);
      tests++;
      if (obs_sig !== exp_sig) begin
        fails++;
        $display("FAIL prog_bytes[%0d] got=%h want=%h", i, obs_sig, exp_sig);
      end
      tests++;
      if (obs_tim !== exp_tim) begin
        fails++;
        $display("FAIL prog_phases[%0d] got=%h want=%h", i, obs_tim, exp_tim);
      end
      tests++;
      if (obs_done != exp_done || obs_done_n != 1) begin
        fails++;
        $display("FAIL prog_done[%0d] got=%0d x%0d want=%0d x1",
                 i, obs_done, obs_done_n, exp_done);
      end
      tests++;
      if (obs_ready != exp_ready || obs_err_n != 0 || obs_viol != 0) begin
        fails++;
        $display("FAIL prog_proto[%0d] ready=%0d err=%0d viol=%0d want %0d/0/0",
                 i, obs_ready, obs_err_n, obs_viol, exp_ready);
      end
    end
  endtask

  task automatic test_latch_read();
    logic [1:0] ch, rw;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        model(1'b0, 1'b0, 2'd1, 2'd3, 3'd2, 16'h8000);
        run_req(1'b0, 1'b0, 2'd1, 2'd3, 3'd2, 16'h8000, 1'b0);
        tests++;
        if (obs_sig !== exp_sig || obs_done != exp_done) begin
          fails++;
          $display("FAIL lr_setup got=%h/%0d want=%h/%0d",
                   obs_sig, obs_done, exp_sig, exp_done);
        end
        ch = 2'd1; rw = 2'd3;
        rq_b[0] = 8'hF0; rq_b[1] = 8'h7F;
      end else begin
        ch = 2'($urandom_range(0, 2));
        rw = 2'($urandom_range(1, 3));
        rq_b[0] = 8'($urandom); rq_b[1] = 8'($urandom);
      end
      model(1'b0, 1'b1, ch, rw, 3'($urandom), 16'($urandom));
      run_req(1'b0, 1'b1, ch, rw, 3'($urandom), 16'($urandom), 1'b0);
      tests++;
      if (obs_sig !== exp_sig) begin
        fails++;
        $display("FAIL lr_bytes[%0d] got=%h want=%h", i, obs_sig, exp_sig);
      end
      tests++;
      if (obs_rd !== exp_rd) begin
        fails++;
        $display("FAIL lr_count[%0d] got=%h want=%h", i, obs_rd, exp_rd);
      end
      tests++;
      if (obs_done != exp_done || obs_ready != exp_ready || obs_viol != 0) begin
        fails++;
        $display("FAIL lr_timing[%0d] done=%0d ready=%0d viol=%0d want %0d/%0d/0",
                 i, obs_done, obs_ready, obs_viol, exp_done, exp_ready);
      end
    end
  endtask

  task automatic test_reject();
    logic op;
    logic [1:0] ch, rw;
    logic [2:0] md;
    for (int i = 0; i < 10; i++) begin
      op = 1'($urandom); ch = 2'($urandom_range(0, 2));
      rw = 2'($urandom); md = 3'($urandom_range(0, 5));
      unique case (i % 3)
        0: ch = 2'd3;
        1: begin op = 1'b0; md = 3'($urandom_range(6, 7)); end
        default: begin op = 1'b1; rw = 2'd0; end
      endcase
      model(i[0], op, ch, rw, md, 16'($urandom));
      run_req(i[0], op, ch, rw, md, 16'($urandom), 1'b0);
      tests++;
      if (obs_err != 1 || obs_err_n != 1 || obs_done_n != 0) begin
        fails++;
        $display("FAIL reject_pulse[%0d] err@%0d x%0d done x%0d want err@1 x1 done x0",
                 i, obs_err, obs_err_n, obs_done_n);
      end
      tests++;
      if (obs_sig !== exp_sig || obs_ready != exp_ready || obs_viol != 0) begin
        fails++;
        $display("FAIL reject_bus[%0d] bus=%h ready=%0d viol=%0d want %h/%0d/0",
                 i, obs_sig, obs_ready, obs_viol, exp_sig, exp_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    int fall;
    logic prev;
    logic [15:0] cnt;
    cnt = 16'($urandom);
    sel = 1'b0;
    for (int w = 0; w < 60 && rdy0 !== 1'b1; w++) begin
      @(posedge clk); #1;
    end
    req_op = 1'b0; req_chan = 2'd0; req_rw = 2'd3;
    req_mode = 3'd3; req_count = cnt; rv = 1'b1;
    @(posedge clk); #1;
    rv = 1'b0;
    fall = 0; prev = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (!wr0 && prev) fall++;
      prev = wr0;
      if (fall == 3) break;
      @(posedge clk); #1;
    end
    tests++;
    if (fall != 3) begin
      fails++;
      $display("FAIL rstmid_reach strobes=%0d want=3", fall);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({cs0, wr0, rd0, oe0} !== 4'b1110) begin
      fails++;
      $display("FAIL rstmid_pins got=%b want=1110", {cs0, wr0, rd0, oe0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    @(posedge clk); #1;
    tests++;
    if (rdy0 !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_ready got=%b want=1", rdy0);
    end
    model(1'b0, 1'b0, 2'd0, 2'd3, 3'd3, cnt);
    run_req(1'b0, 1'b0, 2'd0, 2'd3, 3'd3, cnt, 1'b0);
    tests++;
    if (obs_sig !== exp_sig || obs_done != exp_done || obs_viol != 0) begin
      fails++;
      $display("FAIL rstmid_next got=%h/%0d/%0d want=%h/%0d/0",
               obs_sig, obs_done, obs_viol, exp_sig, exp_done);
    end
  endtask

  task automatic test_timing();
    logic op;
    logic [1:0] ch, rw;
    for (int i = 0; i < 8; i++) begin
      op = i[0];
      ch = 2'($urandom_range(0, 2));
      rw = (i < 2) ? 2'd3 : 2'($urandom_range(1, 3));
      rq_b[0] = 8'($urandom); rq_b[1] = 8'($urandom);
      model(1'b1, op, ch, rw, 3'($urandom_range(0, 5)), 16'($urandom));
      run_req(1'b1, op, ch, rw, 3'($urandom_range(0, 5)), 16'($urandom), 1'b0);
      tests++;
      if (obs_tim !== exp_tim) begin
        fails++;
        $display("FAIL slow_phases[%0d] got=%h want=%h", i, obs_tim, exp_tim);
      end
      tests++;
      if (obs_viol != 0 || obs_done != exp_done) begin
        fails++;
        $display("FAIL slow_proto[%0d] viol=%0d done=%0d want 0/%0d",
                 i, obs_viol, obs_done, exp_done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic s, op, hv;
    logic [1:0] ch, rw;
    logic [2:0] md;
    logic [15:0] cnt;
    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom); op = 1'($urandom); hv = 1'($urandom);
      ch = 2'($urandom_range(0, 3)); rw = 2'($urandom);
      md = 3'($urandom); cnt = 16'($urandom);
      rq_b[0] = 8'($urandom); rq_b[1] = 8'($urandom);
      model(s, op, ch, rw, md, cnt);
      run_req(s, op, ch, rw, md, cnt, hv);
      tests++;
      if (obs_sig !== exp_sig || obs_tim !== exp_tim) begin
        fails++;
        $display("FAIL b2b_bus[%0d] got=%h/%h want=%h/%h",
                 i, obs_sig, obs_tim, exp_sig, exp_tim);
      end
      tests++;
      if (obs_done != exp_done || obs_err_n != exp_err
          || obs_ready != exp_ready) begin
        fails++;
        $display("FAIL b2b_ctl[%0d] done=%0d err=%0d ready=%0d want %0d/%0d/%0d",
                 i, obs_done, obs_err_n, obs_ready, exp_done, exp_err, exp_ready);
      end
      tests++;
      if (obs_rd !== exp_rd || obs_viol != 0) begin
        fails++;
        $display("FAIL b2b_rd[%0d] got=%h viol=%0d want=%h/0",
                 i, obs_rd, obs_viol, exp_rd);
      end
    end
  endtask

  initial begin
    rq_b[0] = 8'h00; rq_b[1] = 8'h00;
    last_rd[0] = 16'h0; last_rd[1] = 16'h0;
    test_reset();
    test_program();
    test_latch_read();
    test_reject();
    test_reset_mid();
    test_timing();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
